rvvi_tx_arbiter: RTL and testbench
==================================

Name: rvvi_tx_arbiter

Overview:
- Shares the single Ethernet MAC write-data channel between two frame sources.
- Source 0 is the RVVI packetizer. Source 1 is the host/debug control-frame generator.
- Grants whole frames, round-robin, and holds the grant from first beat to Wlast; frames never interleave.
- Inserts a programmable idle gap between frames. Sits between the packetizers and the MAC TX FIFO interface.

Parameters:
- DATA_WIDTH, 32, width of the write-data beat.
- GAP_WIDTH, 16, width of the GapCycles input and the gap counter.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  asynchronous, active-low reset
- Enable  in  1  when 0, no new grant is issued; a frame in progress completes
- GapCycles  in  GAP_WIDTH  idle cycles inserted after each frame's last beat
- S0Wdata  in  DATA_WIDTH  source 0 beat data
- S0Wstrb  in  DATA_WIDTH/8  source 0 byte strobes
- S0Wlast  in  1  source 0 last beat of frame
- S0Wvalid  in  1  source 0 beat valid
- S0Wready  out  1  source 0 beat accepted
- S1Wdata, S1Wstrb, S1Wlast, S1Wvalid, S1Wready  same directions, widths and meaning for source 1
- RvviAxiWdata  out  DATA_WIDTH  to MAC
- RvviAxiWstrb  out  DATA_WIDTH/8  to MAC
- RvviAxiWlast  out  1  to MAC
- RvviAxiWvalid  out  1  to MAC
- RvviAxiWready  in  1  MAC accepts beat
- Grant  out  1  currently or most recently granted source index
- Busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, m_axi_aresetn=0):
  - State=IDLE, Grant=0, internal LastGrant=1 (so source 0 wins the first tie).
  - Gap counter=0.
  - All S*Wready, RvviAxiWvalid, RvviAxiWlast, Busy = 0.
  - RvviAxiWdata and RvviAxiWstrb = 0 while not in GRANT.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - Outputs idle.
  - If Enable and any SxWvalid: Grant <= winner, next state GRANT.
  - Winner when both are valid: the source != LastGrant. When one is valid: that source.
  - Arbitration costs one cycle; the first beat cannot transfer in the same cycle valid first rises.
- GRANT (datapath is combinational pass-through from the granted source):
  - RvviAxiW{data,strb,last,valid} = S[Grant]W*.
  - S[Grant]Wready = RvviAxiWready; the other source's Wready = 0.
  - The granted source may drop valid mid-frame; the grant is held with no timeout.
  - Handshake: a beat transfers when RvviAxiWvalid & RvviAxiWready.
  - On transfer with Wlast=1: LastGrant <= Grant. Next state is IDLE if GapCycles==0, else GAP with gap counter <= 1.
  - Enable is ignored in GRANT.
- GAP:
  - Outputs idle; gap counter increments each cycle.
  - Exit to IDLE when gap counter >= GapCycles (so a mid-gap decrease of GapCycles ends the gap early).
  - Gap counter saturates at all-ones and does not wrap.
- Back-to-back timing: with GapCycles=N>0, the next frame's first beat can appear no earlier than N+2 cycles after the last-beat cycle (N gap cycles plus one IDLE arbitration cycle). With N=0 the minimum is 2 cycles.
- A source that is valid but not granted sees Wready=0 and must hold its data stable.
- Reset asserted mid-frame: immediate return to the reset state. The partial frame is truncated; recovery is the MAC's responsibility.
- Grant holds its value in IDLE and GAP.

Optional Feature:
- Macro: RVVI_ARB_STATS_EN.
- Defined: adds output ports Frames0, Frames1 (16 bits each) and Stall0 (32 bits).
  - FramesX counts completed frames (Wlast handshakes) per source, wraps at 0xFFFF->0.
  - Stall0 counts cycles where S0Wvalid=1 and S0Wready=0, saturates at 0xFFFFFFFF.
  - All reset to 0 asynchronously.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then S0 sends a 4-beat frame (0xA0..0xA3), GapCycles=0, MAC ready always -> Wvalid rises 1 cycle after S0Wvalid; 4 beats pass unmodified; Wlast on 0xA3; Grant=0; S1Wready stays 0.
- Both sources valid in the same cycle after reset, each with a 3-beat frame -> S0 frame first, then S1 frame; no interleaving; Grant goes 0 then 1.
- S1 continuously valid, S0 raises valid mid S1 frame -> S1 frame completes, then S0 is granted before S1's next frame (round-robin).
- GapCycles=5, S0 sends two back-to-back frames -> exactly 5 GAP cycles plus 1 IDLE cycle of Wvalid=0 between S0's last beat and the next first beat.
- Random RvviAxiWready throttling and a mid-frame S0Wvalid drop -> no beat lost or duplicated; data and strb are stable while valid=1 and ready=0; with RVVI_ARB_STATS_EN, Frames0 counts correctly and Stall0 matches the number of stalled cycles.
- m_axi_aresetn pulsed low during beat 2 of a 4-beat frame; separately, Enable=0 with both sources valid -> after reset all outputs are 0, Busy=0, Grant=0, and the next arbitration favours S0; with Enable=0 no grant occurs until Enable=1.

Source files
------------

// File: rtl/rvvi_tx_arbiter.sv
// Whole-frame round-robin arbiter sharing the MAC write-data channel between the
// RVVI packetizer (source 0) and the host/debug frame generator (source 1).
// Define RVVI_ARB_STATS_EN to add the Frames0/Frames1/Stall0 statistics ports.
module rvvi_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_aresetn,
    input  logic                    Enable,
    input  logic [GAP_WIDTH-1:0]    GapCycles,
    input  logic [DATA_WIDTH-1:0]   S0Wdata,
    input  logic [DATA_WIDTH/8-1:0] S0Wstrb,
    input  logic                    S0Wlast,
    input  logic                    S0Wvalid,
    output logic                    S0Wready,
    input  logic [DATA_WIDTH-1:0]   S1Wdata,
    input  logic [DATA_WIDTH/8-1:0] S1Wstrb,
    input  logic                    S1Wlast,
    input  logic                    S1Wvalid,
    output logic                    S1Wready,
    output logic [DATA_WIDTH-1:0]   RvviAxiWdata,
    output logic [DATA_WIDTH/8-1:0] RvviAxiWstrb,
    output logic                    RvviAxiWlast,
    output logic                    RvviAxiWvalid,
    input  logic                    RvviAxiWready,
    output logic                    Grant,
    output logic                    Busy
`ifdef RVVI_ARB_STATS_EN
    ,
    output logic [15:0]             Frames0,
    output logic [15:0]             Frames1,
    output logic [31:0]             Stall0
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic                 grantNext;
    logic                 lastGrant;
    logic                 lastGrantNext;
    logic [GAP_WIDTH-1:0] gapCnt;
    logic [GAP_WIDTH-1:0] gapCntNext;
    logic                 beatXfer;
    logic                 frameDone;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        grantNext     = Grant;
        lastGrantNext = lastGrant;
        gapCntNext    = gapCnt;
        RvviAxiWdata  = '0;
        RvviAxiWstrb  = '0;
        RvviAxiWlast  = 1'b0;
        RvviAxiWvalid = 1'b0;
        S0Wready      = 1'b0;
        S1Wready      = 1'b0;
        beatXfer      = 1'b0;
        frameDone     = 1'b0;
        Busy          = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (Enable && (S0Wvalid || S1Wvalid)) begin
                    // On a tie the source that did not win last time goes next.
                    grantNext = (S0Wvalid && S1Wvalid) ? ~lastGrant : S1Wvalid;
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                if (Grant) begin
                    RvviAxiWdata  = S1Wdata;
                    RvviAxiWstrb  = S1Wstrb;
                    RvviAxiWlast  = S1Wlast;
                    RvviAxiWvalid = S1Wvalid;
                    S1Wready      = RvviAxiWready;
                end else begin
                    RvviAxiWdata  = S0Wdata;
                    RvviAxiWstrb  = S0Wstrb;
                    RvviAxiWlast  = S0Wlast;
                    RvviAxiWvalid = S0Wvalid;
                    S0Wready      = RvviAxiWready;
                end
                beatXfer  = RvviAxiWvalid && RvviAxiWready;
                frameDone = beatXfer && RvviAxiWlast;
                if (frameDone) begin
                    lastGrantNext = Grant;
                    if (GapCycles == '0) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = GAP;
                        gapCntNext = GAP_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gapCnt != '1) begin
                    gapCntNext = gapCnt + GAP_WIDTH'(1);
                end
                // Compare against the live value so shrinking GapCycles ends the gap early.
                if (gapCnt >= GapCycles) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state     <= IDLE;
            Grant     <= 1'b0;
            lastGrant <= 1'b1;
            gapCnt    <= '0;
        end else begin
            state     <= stateNext;
            Grant     <= grantNext;
            lastGrant <= lastGrantNext;
            gapCnt    <= gapCntNext;
        end
    end

`ifdef RVVI_ARB_STATS_EN
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            Frames0 <= '0;
            Frames1 <= '0;
            Stall0  <= '0;
        end else begin
            if (frameDone && !Grant) begin
                Frames0 <= Frames0 + 16'd1;
            end
            if (frameDone && Grant) begin
                Frames1 <= Frames1 + 16'd1;
            end
            if (S0Wvalid && !S0Wready && (Stall0 != '1)) begin
                Stall0 <= Stall0 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Bench for rvvi_tx_arbiter: cycle vector table, directed gap/reset sequences and a
// randomized run scored against per-source beat queues.
module tb_rvvi_tx_arbiter;

    localparam int DW = 32;
    localparam int GW = 16;
    localparam int SW = DW / 8;

    logic          m_axi_aclk = 1'b0;
    logic          m_axi_aresetn = 1'b0;
    logic          Enable;
    logic [GW-1:0] GapCycles;
    logic [DW-1:0] S0Wdata, S1Wdata, RvviAxiWdata;
    logic [SW-1:0] S0Wstrb, S1Wstrb, RvviAxiWstrb;
    logic          S0Wlast, S0Wvalid, S0Wready;
    logic          S1Wlast, S1Wvalid, S1Wready;
    logic          RvviAxiWlast, RvviAxiWvalid, RvviAxiWready;
    logic          Grant, Busy;
`ifdef RVVI_ARB_STATS_EN
    logic [15:0]   Frames0, Frames1;
    logic [31:0]   Stall0;
`endif

    rvvi_tx_arbiter #(.DATA_WIDTH(DW), .GAP_WIDTH(GW)) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
        .Enable(Enable), .GapCycles(GapCycles),
        .S0Wdata(S0Wdata), .S0Wstrb(S0Wstrb), .S0Wlast(S0Wlast),
        .S0Wvalid(S0Wvalid), .S0Wready(S0Wready),
        .S1Wdata(S1Wdata), .S1Wstrb(S1Wstrb), .S1Wlast(S1Wlast),
        .S1Wvalid(S1Wvalid), .S1Wready(S1Wready),
        .RvviAxiWdata(RvviAxiWdata), .RvviAxiWstrb(RvviAxiWstrb),
        .RvviAxiWlast(RvviAxiWlast), .RvviAxiWvalid(RvviAxiWvalid),
        .RvviAxiWready(RvviAxiWready),
        .Grant(Grant), .Busy(Busy)
`ifdef RVVI_ARB_STATS_EN
        , .Frames0(Frames0), .Frames1(Frames1), .Stall0(Stall0)
`endif
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic driveIdle();
        S0Wvalid = 1'b0; S0Wdata = '0; S0Wstrb = '0; S0Wlast = 1'b0;
        S1Wvalid = 1'b0; S1Wdata = '0; S1Wstrb = '0; S1Wlast = 1'b0;
        RvviAxiWready = 1'b1;
    endtask

    task automatic doReset();
        m_axi_aresetn = 1'b0;
        driveIdle();
        tick();
        tick();
        m_axi_aresetn = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        bit         s0v;
        logic [7:0] s0d;
        bit         s0l;
        bit         s1v;
        logic [7:0] s1d;
        bit         s1l;
        bit         rdy;
        bit         wv;
        logic [7:0] wd;
        bit         wl;
        bit         r0;
        bit         r1;
        bit         g;
        bit         b;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(bit rst, bit en, bit s0v, logic [7:0] s0d, bit s0l,
                                   bit s1v, logic [7:0] s1d, bit s1l, bit rdy,
                                   bit wv, logic [7:0] wd, bit wl, bit r0, bit r1, bit g, bit b);
        vec_t v;
        v.rst = rst; v.en = en; v.s0v = s0v; v.s0d = s0d; v.s0l = s0l;
        v.s1v = s1v; v.s1d = s1d; v.s1l = s1l; v.rdy = rdy;
        v.wv = wv; v.wd = wd; v.wl = wl; v.r0 = r0; v.r1 = r1; v.g = g; v.b = b;
        vecs.push_back(v);
    endfunction

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    beat_t srcQ[2][$];
    beat_t expQ[2][$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Enable = 1'b1;
        GapCycles = '0;
        driveIdle();

        //     rst en s0v s0d   s0l s1v s1d   s1l rdy | wv wd    wl r0 r1 g  b
        // Single 4-beat S0 frame: one arbitration cycle, then pass-through.
        addVec(1, 1, 1, 8'hA0, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 8'hA0, 0, 0, 8'h00, 0, 1,   1, 8'hA0, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'hA1, 0, 0, 8'h00, 0, 1,   1, 8'hA1, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'hA2, 0, 0, 8'h00, 0, 1,   1, 8'hA2, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'hA3, 1, 0, 8'h00, 0, 1,   1, 8'hA3, 1, 1, 0, 0, 1);
        addVec(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        // Simultaneous request: S0 first, S1 held off until S0's last beat.
        addVec(1, 1, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 8'hB0, 0, 1, 8'hC0, 0, 1,   1, 8'hB0, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'hB1, 0, 1, 8'hC0, 0, 1,   1, 8'hB1, 0, 1, 0, 0, 1);
        addVec(0, 1, 1, 8'hB2, 1, 1, 8'hC0, 0, 1,   1, 8'hB2, 1, 1, 0, 0, 1);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hC0, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hC0, 0, 1,   1, 8'hC0, 0, 0, 1, 1, 1);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hC1, 0, 1,   1, 8'hC1, 0, 0, 1, 1, 1);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hC2, 1, 1,   1, 8'hC2, 1, 0, 1, 1, 1);
        addVec(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        // S1 streaming, S0 arrives mid-frame and wins the next arbitration.
        addVec(1, 1, 0, 8'h00, 0, 1, 8'hD0, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hD0, 0, 1,   1, 8'hD0, 0, 0, 1, 1, 1);
        addVec(0, 1, 1, 8'hE0, 1, 1, 8'hD1, 0, 1,   1, 8'hD1, 0, 0, 1, 1, 1);
        addVec(0, 1, 1, 8'hE0, 1, 1, 8'hD2, 1, 1,   1, 8'hD2, 1, 0, 1, 1, 1);
        addVec(0, 1, 1, 8'hE0, 1, 1, 8'hD3, 1, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        addVec(0, 1, 1, 8'hE0, 1, 1, 8'hD3, 1, 1,   1, 8'hE0, 1, 1, 0, 0, 1);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hD3, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hD3, 1, 1,   1, 8'hD3, 1, 0, 1, 1, 1);
        addVec(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        // Enable low blocks arbitration; a MAC stall holds the beat.
        addVec(1, 0, 1, 8'hF0, 1, 1, 8'hF8, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 8'hF0, 1, 1, 8'hF8, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 8'hF0, 1, 1, 8'hF8, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 8'hF0, 1, 1, 8'hF8, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 8'hF0, 1, 1, 8'hF8, 1, 0,   1, 8'hF0, 1, 0, 0, 0, 1);
        addVec(0, 1, 1, 8'hF0, 1, 1, 8'hF8, 1, 1,   1, 8'hF0, 1, 1, 0, 0, 1);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hF8, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 8'h00, 0, 1, 8'hF8, 1, 1,   1, 8'hF8, 1, 0, 1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [SW-1:0] expStrb;
            v = vecs[i];
            if (v.rst) doReset();
            Enable = v.en;
            S0Wvalid = v.s0v; S0Wdata = {24'h0, v.s0d}; S0Wstrb = 4'hF; S0Wlast = v.s0l;
            S1Wvalid = v.s1v; S1Wdata = {24'h0, v.s1d}; S1Wstrb = 4'h5; S1Wlast = v.s1l;
            RvviAxiWready = v.rdy;
            #1;
            expStrb = v.wv ? (v.g ? 4'h5 : 4'hF) : 4'h0;
            check($sformatf("v%0d wvalid", i), RvviAxiWvalid, v.wv);
            check($sformatf("v%0d wdata", i), RvviAxiWdata, {24'h0, v.wd});
            check($sformatf("v%0d wstrb", i), RvviAxiWstrb, expStrb);
            check($sformatf("v%0d wlast", i), RvviAxiWlast, v.wl);
            check($sformatf("v%0d s0ready", i), S0Wready, v.r0);
            check($sformatf("v%0d s1ready", i), S1Wready, v.r1);
            check($sformatf("v%0d grant", i), Grant, v.g);
            check($sformatf("v%0d busy", i), Busy, v.b);
            tick();
        end
        Enable = 1'b1;

        // Two back-to-back S0 frames with a 5-cycle gap.
        begin
            logic [7:0] gd[4];
            int idx, tLast, tFirst, idleCnt;
            gd[0] = 8'h50; gd[1] = 8'h51; gd[2] = 8'h60; gd[3] = 8'h61;
            idx = 0; tLast = -1; tFirst = -1; idleCnt = 0;
            doReset();
            GapCycles = 16'd5;
            for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
                S0Wvalid = 1'b1; S0Wdata = {24'h0, gd[idx]}; S0Wstrb = 4'hF;
                S0Wlast = (idx == 1) || (idx == 3);
                #1;
                if (idx == 2 && tLast >= 0 && !RvviAxiWvalid) idleCnt++;
                if (RvviAxiWvalid && RvviAxiWready) begin
                    if (idx == 1) tLast = cyc;
                    if (idx == 2) tFirst = cyc;
                    idx++;
                end
                tick();
            end
            driveIdle();
            check("gap frames done", idx, 4);
            check("gap spacing", tFirst - tLast, 7);
            check("gap idle cycles", idleCnt, 6);
        end

        // Reset during beat 2 of a 4-beat S0 frame, after S0 already won once.
        doReset();
        GapCycles = '0;
        S0Wvalid = 1'b1; S0Wdata = 32'h70; S0Wstrb = 4'hF; S0Wlast = 1'b1;
        tick();
        tick();
        S0Wdata = 32'h80; S0Wlast = 1'b0;
        tick();
        tick();
        S0Wdata = 32'h81;
        #1;
        check("pre-reset beat2", RvviAxiWdata, 32'h81);
        m_axi_aresetn = 1'b0;
        #1;
        check("rst wvalid", RvviAxiWvalid, 0);
        check("rst wdata", RvviAxiWdata, 0);
        check("rst wstrb", RvviAxiWstrb, 0);
        check("rst wlast", RvviAxiWlast, 0);
        check("rst s0ready", S0Wready, 0);
        check("rst s1ready", S1Wready, 0);
        check("rst busy", Busy, 0);
        check("rst grant", Grant, 0);
        tick();
        tick();
        m_axi_aresetn = 1'b1;
        S0Wdata = 32'h90; S0Wlast = 1'b1;
        S1Wvalid = 1'b1; S1Wdata = 32'h91; S1Wstrb = 4'h5; S1Wlast = 1'b1;
        #1;
        check("post-reset idle", RvviAxiWvalid, 0);
        tick();
        check("post-reset winner grant", Grant, 0);
        check("post-reset winner data", RvviAxiWdata, 32'h90);
        tick();
        driveIdle();

        // Randomized traffic with MAC throttling and source valid bubbles.
        begin
            int n, lastEnd, stallExp, len;
            bit curV[2], acc[2], h[2];
            beat_t curB[2], b, prevB;
            bit prevStall, prevValid, measuring, inFrame, owner, g, done;
            n = $urandom_range(0, 3);
            GapCycles = GW'(n);
            doReset();
            for (int s = 0; s < 2; s++) begin
                for (int f = 0; f < 10; f++) begin
                    len = $urandom_range(1, 5);
                    for (int k = 0; k < len; k++) begin
                        b.d = $urandom;
                        b.s = SW'($urandom_range(1, 15));
                        b.l = (k == len - 1);
                        srcQ[s].push_back(b);
                        expQ[s].push_back(b);
                    end
                end
            end
            curV = '{0, 0}; acc = '{0, 0};
            prevStall = 0; prevValid = 0; measuring = 0; inFrame = 0; owner = 0;
            lastEnd = 0; stallExp = 0; done = 0;
            for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
                for (int s = 0; s < 2; s++) begin
                    if (acc[s] || !curV[s]) begin
                        if (srcQ[s].size() != 0 && $urandom_range(0, 3) != 0) begin
                            curV[s] = 1'b1;
                            curB[s] = srcQ[s][0];
                        end else begin
                            curV[s] = 1'b0;
                        end
                    end
                end
                S0Wvalid = curV[0]; S0Wdata = curB[0].d; S0Wstrb = curB[0].s; S0Wlast = curB[0].l;
                S1Wvalid = curV[1]; S1Wdata = curB[1].d; S1Wstrb = curB[1].s; S1Wlast = curB[1].l;
                RvviAxiWready = ($urandom_range(0, 9) < 7);
                #1;
                h[0] = S0Wvalid && S0Wready;
                h[1] = S1Wvalid && S1Wready;
                if (prevStall) begin
                    check("stall hold valid", RvviAxiWvalid, 1);
                    check("stall hold beat", {RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast}, prevB);
                end
                if (RvviAxiWvalid && !prevValid && measuring) begin
                    check("min gap", (cyc - lastEnd) >= (n + 2), 1);
                    measuring = 0;
                end
                if (RvviAxiWvalid && RvviAxiWready) begin
                    g = Grant;
                    check("src handshake", {h[g], h[!g]}, 2'b10);
                    if (inFrame) check("no interleave", Grant, owner);
                    check("beat expected", expQ[g].size() != 0, 1);
                    if (expQ[g].size() != 0) begin
                        check("beat", {RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast}, expQ[g][0]);
                        void'(expQ[g].pop_front());
                    end
                    if (RvviAxiWlast) begin
                        inFrame = 0; measuring = 1; lastEnd = cyc;
                    end else begin
                        inFrame = 1; owner = g;
                    end
                end
                if (S0Wvalid && !S0Wready) stallExp++;
                for (int s = 0; s < 2; s++) begin
                    acc[s] = h[s];
                    if (h[s]) void'(srcQ[s].pop_front());
                end
                prevStall = RvviAxiWvalid && !RvviAxiWready;
                prevValid = RvviAxiWvalid;
                prevB = {RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast};
                done = (srcQ[0].size() == 0) && (srcQ[1].size() == 0) &&
                       (expQ[0].size() == 0) && (expQ[1].size() == 0);
                tick();
            end
            check("random drained", srcQ[0].size() + srcQ[1].size() + expQ[0].size() + expQ[1].size(), 0);
`ifdef RVVI_ARB_STATS_EN
            check("frames0", Frames0, 10);
            check("frames1", Frames1, 10);
            check("stall0", Stall0, stallExp);
`endif
            driveIdle();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
